control_unit: RTL and testbench
===============================

# control_unit

Instruction-sequencing controller and accumulator datapath that sits directly downstream of the program-memory/PC/IR stage. It consumes the instruction register, drives that stage's `IRload`, `PClocd` and `Jmux` controls, executes each instruction against an internal accumulator, and presents results on a registered output port. Every instruction takes three cycles: WAIT, FETCH and EXEC.

## Interface
- `ADDR_LEN`, 4: PC width. The jump target is `IR[ADDR_LEN-1:0]`.
- `INSTRUCTION_LEN`, 10: stored instruction width. `IR` is `INSTRUCTION_LEN+1` bits wide and `IR[INSTRUCTION_LEN]` is ignored.
- `DATA_LEN`, 7: accumulator and immediate width. The immediate is `IR[DATA_LEN-1:0]`. The requirement is `DATA_LEN <= INSTRUCTION_LEN-3` and `ADDR_LEN <= DATA_LEN`.

Ports:
- `Clock`  in  1  system clock, rising edge.
- `Reset`  in  1  synchronous, active-high.
- `Start`  in  1  level-sampled run request. Acts only in INIT.
- `IR`  in  `INSTRUCTION_LEN+1`  current instruction register.
- `IRload`  out  1  load IR from program memory.
- `PClocd`  out  1  PC load enable.
- `Jmux`  out  1  1 = PC+1, 0 = jump target.
- `Dout`  out  `DATA_LEN`  registered output value.
- `OutValid`  out  1  one-cycle pulse when `Dout` is updated.
- `Halted`  out  1  high while in HALT.
- `Step`  in  1  present only with `CU_SINGLE_STEP_EN`.

## Operation
- The opcode is `IR[INSTRUCTION_LEN-1:INSTRUCTION_LEN-3]`:
  - 000 NOP.
  - 001 LDI: A ← imm.
  - 010 ADD: A ← A+imm.
  - 011 SUB: A ← A−imm.
  - 100 JMP.
  - 101 JZ: jump if A==0.
  - 110 OUT: Dout ← A.
  - 111 HALT.
- Arithmetic is modulo 2^`DATA_LEN`. Carry and borrow are discarded.
- The JZ test uses A as it stands at the start of EXEC.
- States and transitions:
  - INIT → WAIT when `Start`=1. Otherwise remain in INIT.
  - WAIT → FETCH unconditionally. WAIT covers the one-cycle synchronous memory read latency.
  - FETCH → EXEC. FETCH asserts `IRload`=1, `PClocd`=1 and `Jmux`=1, so IR captures the instruction at the old PC and PC advances by one.
  - EXEC → HALT on HALT. Otherwise EXEC → WAIT, or → PAUSE when single-step is enabled.
  - In EXEC, JMP and taken JZ assert `PClocd`=1 with `Jmux`=0. A not-taken JZ asserts no PC load.
  - HALT: remain until `Reset`. `Halted`=1.
- `Jmux` is 1 in every cycle except the EXEC cycle of a taken jump.
- `IRload` and `PClocd` are 0 outside the cases listed above.
- PC wrap-around (max → 0) belongs to the upstream stage. This block does nothing special at wrap-around.

## Timing
- Reset:
  - In any cycle where `Reset`=1, `IRload`, `PClocd` and `Jmux` are combinationally forced to 0, 0 and 1.
  - At the next edge: state=INIT, A=0, `Dout`=0, `OutValid`=0, `Halted`=0.
  - Reset mid-instruction (any state) aborts the instruction with no A or `Dout` update.
  - `Reset` and `Start` high together: Reset wins.
- Control outputs are combinational from state and IR, with no extra latency.
- `Start` sampled high at edge n:
  - WAIT in cycle n+1.
  - FETCH in cycle n+2.
  - EXEC in cycle n+3.
  - A, `Dout` and PC (for jumps) update at the edge ending EXEC.
- OUT:
  - `Dout` is registered at the end of EXEC.
  - `OutValid`=1 for exactly the following cycle.
  - `Dout` holds its value until the next OUT or Reset.
- Steady-state throughput is one instruction per 3 cycles.
- `Halted` rises in the cycle after the EXEC of HALT.

## Configuration
- `CU_SINGLE_STEP_EN` defined:
  - Adds the `Step` input and a PAUSE state.
  - EXEC of any non-HALT instruction goes to PAUSE.
  - PAUSE asserts no controls and goes to WAIT on the first cycle `Step`=1.
  - `Reset` in PAUSE returns to INIT.
- `CU_SINGLE_STEP_EN` undefined:
  - No `Step` port and no PAUSE state.
  - EXEC goes directly to WAIT.

## Test plan
- Reset:
  - Stimulus: hold `Reset` 2 cycles, `Start`=0.
  - Response: `IRload`=0, `PClocd`=0, `Jmux`=1, `Dout`=0, `OutValid`=0, `Halted`=0. The FSM stays in INIT for 10 cycles.
- Arithmetic and OUT:
  - Stimulus: program LDI 5, ADD 3, SUB 10, OUT, HALT, with `Start` pulsed.
  - Response: `Dout`=126 (7-bit wrap), `OutValid` pulses once, and `Halted`=1 exactly 15 cycles after the Start edge.
- Jumps:
  - Stimulus: program LDI 0 at 0, JZ 4 at 1, OUT at 2, HALT at 4.
  - Response: `PClocd`=1 with `Jmux`=0 in the JZ EXEC, `OutValid` never asserts, PC reaches 5.
  - Stimulus: the same program with LDI 1.
  - Response: no PC load in the JZ EXEC, and OUT yields `Dout`=1.
- Unconditional jump at wrap:
  - Stimulus: JMP 0 at address 15.
  - Response: PC goes to 0 and execution loops. `IRload` pulses every 3 cycles.
- Reset mid-run:
  - Stimulus: assert `Reset` during the FETCH of ADD.
  - Response: A stays 0 and the FSM is in INIT after the edge. After re-Start, execution restarts from PC 0.
- `CU_SINGLE_STEP_EN`:
  - Stimulus: `Step`=0 after the first EXEC.
  - Response: the FSM holds in PAUSE with no `IRload`.
  - Stimulus: one `Step` pulse.
  - Response: exactly one more instruction executes.

Source files
------------

// File: rtl/control_unit_if.sv
// control_unit_if: bus between the program-memory/PC/IR stage and the
// instruction-sequencing controller. The controller side uses the master
// modport (consumes IR, drives the stage controls and the result port);
// the upstream stage or an observer uses the slave modport.
interface control_unit_if #(
    parameter int INSTRUCTION_LEN = 10,
    parameter int DATA_LEN        = 7
);
    logic [INSTRUCTION_LEN:0] IR;
    logic                     IRload;
    logic                     PClocd;
    logic                     Jmux;
    logic [DATA_LEN-1:0]      Dout;
    logic                     OutValid;
    logic                     Halted;

    modport master (
        input  IR,
        output IRload, PClocd, Jmux, Dout, OutValid, Halted
    );

    modport slave (
        output IR,
        input  IRload, PClocd, Jmux, Dout, OutValid, Halted
    );
endinterface

// File: rtl/control_unit.sv
// control_unit: three-cycle (WAIT, FETCH, EXEC) instruction sequencer with
// an accumulator datapath. Drives IRload/PClocd/Jmux of the upstream
// PC/IR stage combinationally from state and IR, and presents OUT results
// on a registered Dout with a one-cycle OutValid pulse.
// Optional feature macro: CU_SINGLE_STEP_EN adds the Step input and a
// PAUSE state entered after every non-HALT EXEC.
module control_unit #(
    parameter int ADDR_LEN        = 4,
    parameter int INSTRUCTION_LEN = 10,
    parameter int DATA_LEN        = 7
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           Start,
`ifdef CU_SINGLE_STEP_EN
    input  logic           Step,
`endif
    control_unit_if.master bus
);

    // Immediate must fit below the opcode and a jump target inside the immediate.
    if (DATA_LEN > INSTRUCTION_LEN - 3 || ADDR_LEN > DATA_LEN) begin : g_param_check
        $error("control_unit: illegal ADDR_LEN/DATA_LEN/INSTRUCTION_LEN combination");
    end

`ifdef CU_SINGLE_STEP_EN
    typedef enum logic [2:0] {
        S_INIT, S_WAIT, S_FETCH, S_EXEC, S_HALT, S_PAUSE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_INIT, S_WAIT, S_FETCH, S_EXEC, S_HALT
    } state_t;
`endif

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LDI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_JMP  = 3'b100,
        OP_JZ   = 3'b101,
        OP_OUT  = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    state_t              state_q;
    logic [DATA_LEN-1:0] acc_q;
    logic [DATA_LEN-1:0] acc_d;
    logic [DATA_LEN-1:0] dout_q;
    logic                out_valid_q;
    logic                halted_q;

    opcode_t             opcode;
    logic [DATA_LEN-1:0] imm;
    logic                jump_taken;
    logic                ir_load;
    logic                pc_load;
    logic                jmux;

    // The stored-instruction MSB carries no meaning for this block.
    logic unused_ir_msb;
    assign unused_ir_msb = bus.IR[INSTRUCTION_LEN];

    // Decode the current instruction and compute the accumulator result.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        opcode     = opcode_t'(bus.IR[INSTRUCTION_LEN-1 -: 3]);
        imm        = bus.IR[DATA_LEN-1:0];
        jump_taken = (opcode == OP_JMP) || ((opcode == OP_JZ) && (acc_q == '0));
        acc_d      = acc_q;
        case (opcode)
            OP_LDI:  acc_d = imm;
            OP_ADD:  acc_d = acc_q + imm;
            OP_SUB:  acc_d = acc_q - imm;
            default: acc_d = acc_q;
        endcase
    end

    // Upstream stage controls: decoded from state and IR, overridden while Reset is high.
    always_comb begin
        ir_load = 1'b0;
        pc_load = 1'b0;
        jmux    = 1'b1;
        if (!Reset) begin
            case (state_q)
                S_FETCH: begin
                    ir_load = 1'b1;
                    pc_load = 1'b1;
                end
                S_EXEC: begin
                    if (jump_taken) begin
                        pc_load = 1'b1;
                        jmux    = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequencer, accumulator and registered result port.
    always_ff @(posedge Clock) begin
        // NOTE: Reset is synchronous and active-high, so it is tested inside the clocked block rather than in the sensitivity list.
        if (Reset) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            state_q     <= S_INIT;
            acc_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    if (Start) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    acc_q <= acc_d;
                    if (opcode == OP_OUT) begin
                        dout_q      <= acc_q;
                        out_valid_q <= 1'b1;
                    end
                    if (opcode == OP_HALT) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
`ifdef CU_SINGLE_STEP_EN
                        state_q <= S_PAUSE;
`else
                        state_q <= S_WAIT;
`endif
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
`ifdef CU_SINGLE_STEP_EN
                S_PAUSE: begin
                    if (Step) begin
                        state_q <= S_WAIT;
                    end
                end
`endif
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign bus.IRload   = ir_load;
    assign bus.PClocd   = pc_load;
    assign bus.Jmux     = jmux;
    assign bus.Dout     = dout_q;
    assign bus.OutValid = out_valid_q;
    assign bus.Halted   = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: self-checking bench for control_unit. Models the upstream
// program-memory/PC/IR stage (synchronous memory read, PC, IR), runs a table
// of short programs, hand-written multi-cycle sequences, and random programs
// checked against an instruction-level reference interpreter.
module tb_control_unit;

    localparam int IL = 10;
    localparam int DL = 7;
`ifdef CU_SINGLE_STEP_EN
    localparam int CPI = 4;
`else
    localparam int CPI = 3;
`endif

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDI  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_JMP  = 3'd4;
    localparam logic [2:0] OP_JZ   = 3'd5;
    localparam logic [2:0] OP_OUT  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef struct {
        logic [6:0] a;
        logic [2:0] op;
        logic [6:0] imm;
        int         exp_dout;
        int         exp_outs;
        int         exp_instr;
    } vec_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
`ifdef CU_SINGLE_STEP_EN
    logic step  = 1'b1;
`endif

    logic [IL:0] mem [16];
    logic [IL:0] mem_q;
    logic [IL:0] ir_q;
    logic [3:0]  pc_q;

    int n_checks = 0;
    int n_bad    = 0;
    int halt_cycle;
    int got_outs[$];
    int exp_outs[$];
    int exp_n;

    control_unit_if #(.INSTRUCTION_LEN(IL), .DATA_LEN(DL)) bus ();

    control_unit #(
        .ADDR_LEN(4),
        .INSTRUCTION_LEN(IL),
        .DATA_LEN(DL)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .Start(start),
`ifdef CU_SINGLE_STEP_EN
        .Step(step),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Upstream stage: synchronous program memory, PC and IR.
    assign bus.IR = ir_q;
    always @(posedge clk) begin
        if (rst) begin
            pc_q  <= 4'd0;
            ir_q  <= '0;
            mem_q <= '0;
        end else begin
            mem_q <= mem[pc_q];
            if (bus.IRload) ir_q <= mem_q;
            if (bus.PClocd) pc_q <= bus.Jmux ? pc_q + 4'd1 : ir_q[3:0];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic logic [IL:0] enc(input logic [2:0] op, input logic [6:0] imm);
        return {1'b0, op, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_nops();
        for (int i = 0; i < 16; i++) mem[i] = enc(OP_NOP, 7'd0);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Returns just after the Start edge: the following sample (c=0) is WAIT.
    task automatic start_prog(input bit with_reset);
        if (with_reset) do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_prog(input bit with_reset, input int budget);
        got_outs.delete();
        halt_cycle = -1;
        start_prog(with_reset);
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (bus.OutValid) got_outs.push_back(int'(bus.Dout));
            if (bus.Halted) begin
                halt_cycle = c;
                break;
            end
        end
    endtask

    // Instruction-level interpreter: result is the OUT value list and the
    // 1-based index of the HALT instruction (or -1 if none within the limit).
    task automatic ref_run(input int max_instr);
        int          pc;
        int          a;
        int          op;
        int          imm;
        logic [IL:0] ins;
        pc = 0;
        a  = 0;
        exp_outs.delete();
        exp_n = -1;
        for (int k = 1; k <= max_instr; k++) begin
            ins = mem[pc];
            op  = int'(ins[9:7]);
            imm = int'(ins[6:0]);
            pc  = (pc + 1) % 16;
            case (op)
                1: a = imm;
                2: a = (a + imm) % 128;
                3: a = (a - imm + 128) % 128;
                4: pc = imm % 16;
                5: if (a == 0) pc = imm % 16;
                6: exp_outs.push_back(a);
                7: begin
                    exp_n = k;
                    return;
                end
                default: ;
            endcase
        end
    endtask

    function automatic int halt_at(input int n_instr);
        return (n_instr < 0) ? -1 : CPI * (n_instr - 1) + 3;
    endfunction

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{7'd5,   OP_ADD,  7'd3,   8,   1, 4};
        vecs[1]  = '{7'd5,   OP_SUB,  7'd10,  123, 1, 4};
        vecs[2]  = '{7'd100, OP_ADD,  7'd100, 72,  1, 4};
        vecs[3]  = '{7'd0,   OP_SUB,  7'd1,   127, 1, 4};
        vecs[4]  = '{7'd127, OP_ADD,  7'd1,   0,   1, 4};
        vecs[5]  = '{7'd9,   OP_NOP,  7'd0,   9,   1, 4};
        vecs[6]  = '{7'd9,   OP_LDI,  7'd44,  44,  1, 4};
        vecs[7]  = '{7'd0,   OP_JZ,   7'd3,   0,   0, 3};
        vecs[8]  = '{7'd1,   OP_JZ,   7'd3,   1,   1, 4};
        vecs[9]  = '{7'd7,   OP_JMP,  7'd3,   0,   0, 3};
        vecs[10] = '{7'd7,   OP_OUT,  7'd0,   7,   2, 4};
        vecs[11] = '{7'd7,   OP_HALT, 7'd0,   0,   0, 2};
        vecs[12] = '{7'd64,  OP_SUB,  7'd64,  0,   1, 4};

        load_nops();

        // Reset state: controls forced during reset, registers cleared after it.
        rst = 1'b1;
        tick();
        check("rst_irload", bus.IRload, 0);
        check("rst_pclocd", bus.PClocd, 0);
        check("rst_jmux", bus.Jmux, 1);
        tick();
        check("rst_dout", bus.Dout, 0);
        check("rst_outvalid", bus.OutValid, 0);
        check("rst_halted", bus.Halted, 0);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("init_idle_%0d", c), {bus.IRload, bus.PClocd, bus.Jmux, bus.Halted}, 4'b0010);
        end

        // Reset and Start together: Reset wins, the FSM stays in INIT.
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("rst_beats_start_%0d", c), bus.IRload, 0);
        end

        // Table of two-instruction kernels: LDI a; op imm; OUT; HALT.
        foreach (vecs[i]) begin
            load_nops();
            mem[0] = enc(OP_LDI, vecs[i].a);
            mem[1] = enc(vecs[i].op, vecs[i].imm);
            mem[2] = enc(OP_OUT, 7'd0);
            mem[3] = enc(OP_HALT, 7'd0);
            run_prog(1'b1, CPI * 10);
            check($sformatf("vec%0d_halt_cycle", i), halt_cycle, halt_at(vecs[i].exp_instr));
            check($sformatf("vec%0d_out_count", i), got_outs.size(), vecs[i].exp_outs);
            check($sformatf("vec%0d_dout", i), bus.Dout, vecs[i].exp_dout);
        end

        // Arithmetic with 7-bit wrap, single OUT pulse, Halted 15 cycles after Start.
        load_nops();
        mem[0] = enc(OP_LDI, 7'd5);
        mem[1] = enc(OP_ADD, 7'd3);
        mem[2] = enc(OP_SUB, 7'd10);
        mem[3] = enc(OP_OUT, 7'd0);
        mem[4] = enc(OP_HALT, 7'd0);
        run_prog(1'b1, CPI * 10);
        check("arith_halt_cycle", halt_cycle, halt_at(5));
        check("arith_out_count", got_outs.size(), 1);
        check("arith_dout", bus.Dout, 126);
        tick();
        check("arith_halted_holds", bus.Halted, 1);

        // JZ taken / not taken.
        for (int v = 0; v < 2; v++) begin
            int outs;
            load_nops();
            mem[0] = enc(OP_LDI, 7'(v));
            mem[1] = enc(OP_JZ, 7'd4);
            mem[2] = enc(OP_OUT, 7'd0);
            mem[4] = enc(OP_HALT, 7'd0);
            start_prog(1'b1);
            tick();
            check($sformatf("jz%0d_fetch_ctrl", v), {bus.IRload, bus.PClocd, bus.Jmux}, 3'b111);
            repeat (CPI + 1) tick();
            check($sformatf("jz%0d_exec_pclocd", v), bus.PClocd, (v == 0) ? 1 : 0);
            check($sformatf("jz%0d_exec_jmux", v), bus.Jmux, (v == 0) ? 0 : 1);
            check($sformatf("jz%0d_exec_irload", v), bus.IRload, 0);
            outs = 0;
            for (int c = 0; c < CPI * 6 && !bus.Halted; c++) begin
                tick();
                if (bus.OutValid) outs++;
            end
            check($sformatf("jz%0d_halted", v), bus.Halted, 1);
            check($sformatf("jz%0d_out_count", v), outs, (v == 0) ? 0 : 1);
            if (v == 0) check("jz0_pc_final", pc_q, 5);
            else        check("jz1_dout", bus.Dout, 1);
        end

        // JMP 0 from the last address: loop with IRload every CPI cycles.
        begin
            int last;
            int pulses;
            int bad_gap;
            load_nops();
            mem[15] = enc(OP_JMP, 7'd0);
            start_prog(1'b1);
            repeat (2 + CPI * 15) tick();
            check("wrap_jmp_ctrl", {bus.IRload, bus.PClocd, bus.Jmux}, 3'b010);
            tick();
            check("wrap_pc_zero", pc_q, 0);
            last    = -1;
            pulses  = 0;
            bad_gap = 0;
            for (int c = 1; c <= CPI * 6; c++) begin
                tick();
                if (bus.IRload) begin
                    if (last >= 0 && c - last != CPI) bad_gap++;
                    last = c;
                    pulses++;
                end
            end
            check("wrap_irload_pulses", pulses, 6);
            check("wrap_irload_spacing", bad_gap, 0);
        end

        // Reset during FETCH of ADD aborts it; re-Start runs from PC 0 with A=0.
        load_nops();
        mem[0] = enc(OP_ADD, 7'd7);
        mem[1] = enc(OP_OUT, 7'd0);
        mem[2] = enc(OP_HALT, 7'd0);
        start_prog(1'b1);
        tick();
        check("midrst_fetch_irload", bus.IRload, 1);
        rst = 1'b1;
        #1;
        check("midrst_forced_ctrl", {bus.IRload, bus.PClocd, bus.Jmux}, 3'b001);
        tick();
        check("midrst_regs", {bus.Dout, bus.OutValid, bus.Halted}, 9'd0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("midrst_init_%0d", c), bus.IRload, 0);
        end
        run_prog(1'b0, CPI * 6);
        check("midrst_halt_cycle", halt_cycle, halt_at(3));
        check("midrst_out_count", got_outs.size(), 1);
        check("midrst_dout", bus.Dout, 7);

`ifdef CU_SINGLE_STEP_EN
        // Single step: hold in PAUSE, then one Step runs exactly one instruction.
        begin
            int loads;
            int outs;
            load_nops();
            mem[0] = enc(OP_LDI, 7'd3);
            mem[1] = enc(OP_OUT, 7'd0);
            mem[2] = enc(OP_HALT, 7'd0);
            step = 1'b0;
            start_prog(1'b1);
            repeat (3) tick();
            for (int c = 0; c < 6; c++) begin
                tick();
                check($sformatf("pause_hold_%0d", c), {bus.IRload, bus.PClocd, bus.Halted}, 3'b000);
            end
            step = 1'b1;
            tick();
            step  = 1'b0;
            loads = 0;
            outs  = 0;
            for (int c = 0; c < 12; c++) begin
                if (bus.IRload) loads++;
                if (bus.OutValid) outs++;
                tick();
            end
            check("step_irloads", loads, 1);
            check("step_outs", outs, 1);
            check("step_dout", bus.Dout, 3);
            check("step_not_halted", bus.Halted, 0);
            step = 1'b1;
        end
`endif

        // Random programs against the instruction-level interpreter.
        for (int t = 0; t < 20; t++) begin
            logic [2:0] op;
            for (int i = 0; i < 16; i++) begin
                op = 3'($urandom_range(0, 7));
                if (op == OP_HALT && $urandom_range(0, 2) != 0) op = 3'($urandom_range(0, 6));
                mem[i] = {1'($urandom_range(0, 1)), op, 7'($urandom_range(0, 127))};
            end
            ref_run(40);
            run_prog(1'b1, CPI * 40);
            check($sformatf("rand%0d_halt_cycle", t), halt_cycle, halt_at(exp_n));
            check($sformatf("rand%0d_out_count", t), got_outs.size(), exp_outs.size());
            for (int k = 0; k < got_outs.size() && k < exp_outs.size(); k++) begin
                check($sformatf("rand%0d_out%0d", t, k), got_outs[k], exp_outs[k]);
            end
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
